// File: rtl/kron_zero_restore_d2.sv
// Masked zero-mapping front end with an in-order FIFO of the Kronecker delta shares,
// used to undo the zero mapping on the value that comes back from the inverter.
module kron_zero_restore_d2 #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] shared_inp,
  input  logic [2:0]  delta,
  input  logic [15:0] rnd,
  output logic        map_valid,
  output logic [23:0] map_out,
  input  logic        ret_valid,
  input  logic [23:0] ret_inp,
  input  logic [15:0] rnd_ret,
  output logic        out_valid,
  output logic [23:0] out,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [2:0]    r_fifo [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_map_valid;
  logic [23:0]   r_map_out;
  logic          r_out_valid;
  logic [23:0]   r_out;
  logic          r_err;

  logic          w_push;
  logic          w_pop;
  logic          w_underflow;
  logic [2:0]    w_e;

  assign in_ready    = (r_count != FULL_CNT);
  assign w_push      = in_valid && in_ready;
  assign w_pop       = ret_valid && (r_count != '0);
  assign w_underflow = ret_valid && (r_count == '0);
  assign w_e         = r_fifo[r_rd_ptr];

  // Each output share only ever mixes one input share, one delta share and masks.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= delta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_map_valid <= 1'b0;
      r_map_out   <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_map_valid <= w_push;
      r_out_valid <= w_pop;
      if (w_underflow) begin
        r_err <= 1'b1;
      end
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + AW'(1);
        r_map_out <= {shared_inp[23:16] ^ {7'b0, delta[2]} ^ rnd[7:0] ^ rnd[15:8],
                      shared_inp[15:8]  ^ {7'b0, delta[1]} ^ rnd[15:8],
                      shared_inp[7:0]   ^ {7'b0, delta[0]} ^ rnd[7:0]};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_out    <= {ret_inp[23:16] ^ {7'b0, w_e[2]} ^ rnd_ret[7:0] ^ rnd_ret[15:8],
                     ret_inp[15:8]  ^ {7'b0, w_e[1]} ^ rnd_ret[15:8],
                     ret_inp[7:0]   ^ {7'b0, w_e[0]} ^ rnd_ret[7:0]};
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign map_valid = r_map_valid;
  assign map_out   = r_map_out;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign err       = r_err;

endmodule

// File: tb/tb_kron_zero_restore_d2.sv
// Randomised check of kron_zero_restore_d2 against a queue-based model of the delta FIFO.
`timescale 1ns/1ps
module tb_kron_zero_restore_d2;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] shared_inp;
  logic [2:0]  delta;
  logic [15:0] rnd;
  logic        map_valid;
  logic [23:0] map_out;
  logic        ret_valid;
  logic [23:0] ret_inp;
  logic [15:0] rnd_ret;
  logic        out_valid;
  logic [23:0] out;
  logic        err;

  kron_zero_restore_d2 #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .shared_inp(shared_inp), .delta(delta), .rnd(rnd),
    .map_valid(map_valid), .map_out(map_out),
    .ret_valid(ret_valid), .ret_inp(ret_inp), .rnd_ret(rnd_ret),
    .out_valid(out_valid), .out(out), .err(err)
  );

  int checks = 0;
  int errors = 0;

  logic [2:0]  q[$];
  logic        exp_map_valid = 1'b0;
  logic [23:0] exp_map_out   = '0;
  logic        exp_out_valid = 1'b0;
  logic [23:0] exp_out       = '0;
  logic        exp_err       = 1'b0;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [7:0] un(input logic [23:0] x);
    return x[23:16] ^ x[15:8] ^ x[7:0];
  endfunction

  function automatic logic [23:0] share3(input logic [7:0] v);
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    return {a, b, a ^ b ^ v};
  endfunction

  // Output share i = input share i ^ delta share i ^ mask i, masks r0, r1, r0^r1.
  function automatic logic [23:0] maskf(input logic [23:0] s, input logic [2:0] d,
                                        input logic [15:0] r);
    logic [7:0] r0, r1;
    r0 = r[7:0];
    r1 = r[15:8];
    return {s[23:16] ^ {7'b0, d[2]} ^ r0 ^ r1,
            s[15:8]  ^ {7'b0, d[1]} ^ r1,
            s[7:0]   ^ {7'b0, d[0]} ^ r0};
  endfunction

  task automatic cyc(input logic iv, input logic [23:0] sh, input logic [2:0] d,
                     input logic [15:0] r, input logic rv, input logic [23:0] ri,
                     input logic [15:0] rr);
    logic acc, pop;
    logic [2:0] e;
    @(negedge clk);
    in_valid = iv; shared_inp = sh; delta = d; rnd = r;
    ret_valid = rv; ret_inp = ri; rnd_ret = rr;
    acc = iv && (q.size() < DEPTH);
    pop = rv && (q.size() != 0);
    if (rv && q.size() == 0) exp_err = 1'b1;
    exp_map_valid = acc;
    exp_out_valid = pop;
    if (pop) begin
      e = q.pop_front();
      exp_out = maskf(ri, e, rr);
    end
    if (acc) begin
      q.push_back(d);
      exp_map_out = maskf(sh, d, r);
    end
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("map_valid", {23'b0, map_valid}, {23'b0, exp_map_valid});
      chk("map_out",   map_out, exp_map_out);
      chk("out_valid", {23'b0, out_valid}, {23'b0, exp_out_valid});
      chk("out",       out, exp_out);
      chk("err",       {23'b0, err}, {23'b0, exp_err});
      chk("in_ready",  {23'b0, in_ready}, {23'b0, (q.size() < DEPTH)});
    end
  end

  initial begin
    logic [15:0] r;
    int          mode;
    rst_n = 1'b0;
    in_valid = 1'b0; shared_inp = '0; delta = '0; rnd = '0;
    ret_valid = 1'b0; ret_inp = '0; rnd_ret = '0;
    #13;
    chk("rst_map_valid", {23'b0, map_valid}, 24'h0);
    chk("rst_out_valid", {23'b0, out_valid}, 24'h0);
    chk("rst_err",       {23'b0, err}, 24'h0);
    chk("rst_map_out",   map_out, 24'h0);
    chk("rst_out",       out, 24'h0);
    chk("rst_in_ready",  {23'b0, in_ready}, 24'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero byte mapped to 1, then a nonzero byte that must pass through
    cyc(1'b1, 24'hA53C99, 3'b001, 16'h0000, 1'b0, '0, '0);
    after_edge();
    chk("zero_map_valid", {23'b0, map_valid}, 24'h1);
    chk("zero_map_out",   map_out, 24'hA53C98);
    r = 16'($urandom);
    cyc(1'b1, 24'h25A347, 3'b011, r, 1'b0, '0, '0);
    after_edge();
    chk("nz_map_un", {16'b0, un(map_out)}, 24'h0000C1);
    idle();

    // Return path restores zero and leaves a nonzero byte untouched
    cyc(1'b0, '0, '0, '0, 1'b1, share3(8'h01), 16'($urandom));
    after_edge();
    chk("rt_out_valid", {23'b0, out_valid}, 24'h1);
    chk("rt_zero_un",   {16'b0, un(out)}, 24'h000000);
    cyc(1'b0, '0, '0, '0, 1'b1, share3(8'h5A), 16'($urandom));
    after_edge();
    chk("rt_nz_un", {16'b0, un(out)}, 24'h00005A);
    idle();

    // Fill to DEPTH, push while full, then pop and push together at full
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 24'($urandom), 3'($urandom), 16'($urandom), 1'b0, '0, '0);
    after_edge();
    chk("full_in_ready", {23'b0, in_ready}, 24'h0);
    cyc(1'b1, 24'($urandom), 3'($urandom), 16'($urandom), 1'b0, '0, '0);
    cyc(1'b1, 24'($urandom), 3'($urandom), 16'($urandom), 1'b1, 24'($urandom), 16'($urandom));
    after_edge();
    chk("full_pop_ready", {23'b0, in_ready}, 24'h1);

    // Random traffic with bursty modes so the FIFO swings between empty and full
    for (int blk = 0; blk < 30; blk++) begin
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 50; i++) begin
        cyc(($urandom_range(0, 3) < (mode == 0 ? 3 : 1)), 24'($urandom), 3'($urandom),
            16'($urandom),
            (q.size() != 0) && ($urandom_range(0, 3) < (mode == 1 ? 3 : 2)),
            24'($urandom), 16'($urandom));
      end
    end
    while (q.size() != 0)
      cyc(1'b0, '0, '0, '0, 1'b1, 24'($urandom), 16'($urandom));
    idle();

    // Underflow with a simultaneous push, then err must stick through traffic
    cyc(1'b1, 24'($urandom), 3'($urandom), 16'($urandom), 1'b1, 24'($urandom), 16'($urandom));
    after_edge();
    chk("uf_out_valid", {23'b0, out_valid}, 24'h0);
    chk("uf_err",       {23'b0, err}, 24'h1);
    for (int i = 0; i < 40; i++)
      cyc($urandom_range(0, 1) == 1, 24'($urandom), 3'($urandom), 16'($urandom),
          (q.size() != 0) && ($urandom_range(0, 1) == 1), 24'($urandom), 16'($urandom));
    after_edge();
    chk("uf_err_sticky", {23'b0, err}, 24'h1);

    // Reset mid-stream with three pending entries
    while (q.size() != 0)
      cyc(1'b0, '0, '0, '0, 1'b1, 24'($urandom), 16'($urandom));
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 24'($urandom), 3'($urandom), 16'($urandom), 1'b0, '0, '0);
    after_edge();
    chk("pre_rst_map_valid", {23'b0, map_valid}, 24'h1);
    #1;
    in_valid = 1'b0;
    ret_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    exp_map_valid = 1'b0; exp_map_out = '0;
    exp_out_valid = 1'b0; exp_out = '0;
    exp_err = 1'b0;
    #2;
    chk("mid_rst_map_valid", {23'b0, map_valid}, 24'h0);
    chk("mid_rst_map_out",   map_out, 24'h0);
    chk("mid_rst_err",       {23'b0, err}, 24'h0);
    chk("mid_rst_in_ready",  {23'b0, in_ready}, 24'h1);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, '0, '0, '0, 1'b1, 24'($urandom), 16'($urandom));
    after_edge();
    chk("post_rst_err",       {23'b0, err}, 24'h1);
    chk("post_rst_out_valid", {23'b0, out_valid}, 24'h0);
    idle();
    idle();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
